// File: rtl/decode_pkg.sv
// Shared decode definitions: MIPS opcode/funct codes, ALU operation and
// jump/branch encodings, and the ID/EX control bundle.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JR   = 2'b11;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_EQ    = 2'b01;
    localparam logic [1:0] BR_NE    = 2'b10;

    // ALU_FUNCT defers the operation choice to the funct field in EX.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_LUI   = 4'd6,
        ALU_FUNCT = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_t;

    typedef struct packed {
        alu_op_t    ALUOp;
        logic       ALUSrc;
        logic       RegDst;
        logic [1:0] Jump;
        logic [1:0] Branch;
        logic       MemWrite;
        logic       MemRead;
        logic       Mem2Reg;
        logic       RegWrite;
        logic       Illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID input, register-file read port and ID/EX output signals of the
// decode stage; slave is the decode stage, master is its environment.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    import decode_pkg::*;

    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instruction;
    logic [XLEN-1:0] i_pcnext;

    logic [RA_W-1:0] o_reg_RegAddr1;
    logic [RA_W-1:0] o_reg_RegAddr2;
    logic [XLEN-1:0] i_reg_RegData1;
    logic [XLEN-1:0] i_reg_RegData2;

    logic            i_flush;
    logic            i_ready;
    logic            o_valid;
    logic [XLEN-1:0] o_EX_data_RSData;
    logic [XLEN-1:0] o_EX_data_RTData;
    logic [RA_W-1:0] o_EX_data_RSAddr;
    logic [RA_W-1:0] o_EX_data_RTAddr;
    logic [RA_W-1:0] o_EX_data_RDAddr;
    logic [XLEN-1:0] o_EX_data_ExtImm;
    logic [4:0]      o_EX_data_Shamt;
    logic [5:0]      o_EX_data_Funct;
    logic [XLEN-1:0] o_EX_data_PCNext;
    ctrl_t           o_EX_ctrl;

    modport slave (
        input  i_valid, i_instruction, i_pcnext, i_reg_RegData1, i_reg_RegData2,
               i_flush, i_ready,
        output o_ready, o_reg_RegAddr1, o_reg_RegAddr2, o_valid,
               o_EX_data_RSData, o_EX_data_RTData, o_EX_data_RSAddr,
               o_EX_data_RTAddr, o_EX_data_RDAddr, o_EX_data_ExtImm,
               o_EX_data_Shamt, o_EX_data_Funct, o_EX_data_PCNext, o_EX_ctrl
    );

    modport master (
        output i_valid, i_instruction, i_pcnext, i_reg_RegData1, i_reg_RegData2,
               i_flush, i_ready,
        input  o_ready, o_reg_RegAddr1, o_reg_RegAddr2, o_valid,
               o_EX_data_RSData, o_EX_data_RTData, o_EX_data_RSAddr,
               o_EX_data_RTAddr, o_EX_data_RDAddr, o_EX_data_ExtImm,
               o_EX_data_Shamt, o_EX_data_Funct, o_EX_data_PCNext, o_EX_ctrl
    );

endinterface

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct to control-bundle mapping, plus the rt-use flag
// for load-use detection and the immediate extension mode.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       uses_rt,
    output ext_t       ext
);

    always_comb begin
        ctrl    = '0;
        uses_rt = 1'b0;
        ext     = EXT_SIGN;
        case (opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                if (funct == FN_JR) begin
                    ctrl.Jump = JMP_JR;
                end else begin
                    ctrl.ALUOp    = ALU_FUNCT;
                    ctrl.RegDst   = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
            end
            OP_J:   ctrl.Jump = JMP_J;
            OP_JAL: begin
                ctrl.Jump     = JMP_JAL;
                ctrl.RegWrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl.Branch = BR_EQ;
                ctrl.ALUOp  = ALU_SUB;
                uses_rt     = 1'b1;
            end
            OP_BNE: begin
                ctrl.Branch = BR_NE;
                ctrl.ALUOp  = ALU_SUB;
                uses_rt     = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.ALUOp    = ALU_ADD;
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            OP_SLTI: begin
                ctrl.ALUOp    = ALU_SLT;
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            OP_ANDI: begin
                ctrl.ALUOp    = ALU_AND;
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ext           = EXT_ZERO;
            end
            OP_ORI: begin
                ctrl.ALUOp    = ALU_OR;
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ext           = EXT_ZERO;
            end
            OP_XORI: begin
                ctrl.ALUOp    = ALU_XOR;
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ext           = EXT_ZERO;
            end
            OP_LUI: begin
                ctrl.ALUOp    = ALU_LUI;
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ext           = EXT_UPPER;
            end
            OP_LW: begin
                ctrl.ALUOp    = ALU_ADD;
                ctrl.ALUSrc   = 1'b1;
                ctrl.MemRead  = 1'b1;
                ctrl.Mem2Reg  = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            OP_SW: begin
                ctrl.ALUOp    = ALU_ADD;
                ctrl.ALUSrc   = 1'b1;
                ctrl.MemWrite = 1'b1;
                uses_rt       = 1'b1;
            end
            default: ctrl.Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction decode stage with ID/EX pipeline register.
// Define DECODE_LOADUSE_STALL_EN to build in load-use hazard stalling.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
)(
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [15:0]     imm;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;

    ctrl_t           dec_ctrl;
    logic            dec_uses_rt;
    ext_t            dec_ext;
    logic [XLEN-1:0] ext_imm;

    logic            ex_valid;
    ctrl_t           ex_ctrl;
    logic [XLEN-1:0] ex_rs_data;
    logic [XLEN-1:0] ex_rt_data;
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_shamt;
    logic [5:0]      ex_funct;
    logic [XLEN-1:0] ex_pc;

    logic            advance;
    logic            hazard;
    logic            load_valid;

    assign opcode = bus.i_instruction[31:26];
    assign rs     = RA_W'(bus.i_instruction[25:21]);
    assign rt     = RA_W'(bus.i_instruction[20:16]);
    assign rd     = RA_W'(bus.i_instruction[15:11]);
    assign shamt  = bus.i_instruction[10:6];
    assign funct  = bus.i_instruction[5:0];
    assign imm    = bus.i_instruction[15:0];

    decode_ctrl u_decode_ctrl (
        .opcode  (opcode),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .uses_rt (dec_uses_rt),
        .ext     (dec_ext)
    );

    always_comb begin
        case (dec_ext)
            EXT_ZERO:  ext_imm = XLEN'(imm);
            EXT_UPPER: ext_imm = XLEN'({imm, 16'h0000});
            default:   ext_imm = {{(XLEN-16){imm[15]}}, imm};
        endcase
    end

`ifdef DECODE_LOADUSE_STALL_EN
    assign hazard = ex_valid && ex_ctrl.MemRead && (ex_rt != '0) &&
                    ((ex_rt == rs) || (dec_uses_rt && (ex_rt == rt)));
`else
    // Software fills load delay slots; the rt-use flag has no consumer here.
    logic unused_uses_rt;
    assign unused_uses_rt = dec_uses_rt;
    assign hazard         = 1'b0;
`endif

    assign advance    = !ex_valid || bus.i_ready;
    assign load_valid = bus.i_valid && !hazard;
    // A flushed instruction is consumed so the front end does not replay it.
    assign bus.o_ready = advance && (bus.i_flush || !hazard);

    assign bus.o_reg_RegAddr1 = rs;
    assign bus.o_reg_RegAddr2 = rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
            ex_shamt   <= '0;
            ex_funct   <= '0;
            ex_pc      <= '0;
        end else if (bus.i_flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (advance) begin
            ex_valid   <= load_valid;
            ex_ctrl    <= load_valid ? dec_ctrl : '0;
            ex_rs_data <= bus.i_reg_RegData1;
            ex_rt_data <= bus.i_reg_RegData2;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            ex_imm     <= ext_imm;
            ex_shamt   <= shamt;
            ex_funct   <= funct;
            ex_pc      <= bus.i_pcnext;
        end
    end

    assign bus.o_valid          = ex_valid;
    assign bus.o_EX_ctrl        = ex_ctrl;
    assign bus.o_EX_data_RSData = ex_rs_data;
    assign bus.o_EX_data_RTData = ex_rt_data;
    assign bus.o_EX_data_RSAddr = ex_rs;
    assign bus.o_EX_data_RTAddr = ex_rt;
    assign bus.o_EX_data_RDAddr = ex_rd;
    assign bus.o_EX_data_ExtImm = ex_imm;
    assign bus.o_EX_data_Shamt  = ex_shamt;
    assign bus.o_EX_data_Funct  = ex_funct;
    assign bus.o_EX_data_PCNext = ex_pc;

endmodule
